fetch_unit: RTL

- Instruction-fetch stage plus IF/ID pipeline register of the P5 five-stage MIPS pipeline.
- Owns the PC and drives the instruction-memory request/response handshake.
- Honours stalls from the hazard unit and branch/jump redirects from ID, including the architectural delay slot.
- Delivers `Instruction`, `id_pc` and `id_pc4` directly to the ID-stage field decoder.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register for the P5 MIPS pipeline.
// Owns the PC, runs the instruction-memory request/response handshake and
// honours hazard stalls plus branch/jump redirects, always delivering the
// delay-slot word to ID before the redirect target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    input  logic        im_rvalid,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetchPc;
    logic [31:0] r_instr;
    logic [31:0] r_idPc;
    logic        r_idValid;
    logic        r_redirPending;
    logic [31:0] r_redirTarget;
    logic [31:0] r_holdBuf;
    logic [31:0] r_holdPc;

    state_t      w_nextState;
    logic [31:0] w_nextFetchPc;
    logic [31:0] w_nextInstr;
    logic [31:0] w_nextIdPc;
    logic        w_nextIdValid;
    logic        w_nextPending;
    logic [31:0] w_nextTarget;
    logic [31:0] w_nextHoldBuf;
    logic [31:0] w_nextHoldPc;
    logic        w_accept;
    logic        w_transfer;
    logic [31:0] w_advancePc;

    // Next-state and next-register values; a pending redirect beats a fresh
    // one, which beats sequential fetch, and the target is only applied when
    // the delay-slot word actually moves into IF/ID.
    always_comb begin
        w_nextState   = r_state;
        w_nextFetchPc = r_fetchPc;
        w_nextInstr   = r_instr;
        w_nextIdPc    = r_idPc;
        w_nextIdValid = r_idValid;
        w_nextPending = r_redirPending;
        w_nextTarget  = r_redirTarget;
        w_nextHoldBuf = r_holdBuf;
        w_nextHoldPc  = r_holdPc;
        w_transfer    = 1'b0;

        w_accept    = redirect_valid && r_idValid && !stall;
        w_advancePc = r_redirPending ? r_redirTarget
                    : (w_accept ? redirect_pc : r_fetchPc + 32'd4);

        case (r_state)
            IDLE: begin
                w_nextState = FETCH;
            end
            FETCH: begin
                if (im_rvalid) begin
                    if (!stall) begin
                        w_transfer    = 1'b1;
                        w_nextInstr   = im_rdata;
                        w_nextIdPc    = r_fetchPc;
                        w_nextIdValid = 1'b1;
                    end else begin
                        w_nextHoldBuf = im_rdata;
                        w_nextHoldPc  = r_fetchPc;
                        w_nextState   = HOLD;
                    end
                end else if (!stall) begin
                    w_nextInstr   = NOP_WORD;
                    w_nextIdValid = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    w_transfer    = 1'b1;
                    w_nextInstr   = r_holdBuf;
                    w_nextIdPc    = r_holdPc;
                    w_nextIdValid = 1'b1;
                    w_nextState   = FETCH;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_transfer) begin
            w_nextFetchPc = w_advancePc;
            w_nextPending = 1'b0;
        end else if (w_accept) begin
            w_nextPending = 1'b1;
            w_nextTarget  = redirect_pc;
        end
    end

    // State and pipeline registers; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_fetchPc      <= RESET_PC;
            r_instr        <= NOP_WORD;
            r_idPc         <= 32'd0;
            r_idValid      <= 1'b0;
            r_redirPending <= 1'b0;
            r_redirTarget  <= 32'd0;
            r_holdBuf      <= 32'd0;
            r_holdPc       <= 32'd0;
        end else begin
            r_state        <= w_nextState;
            r_fetchPc      <= w_nextFetchPc;
            r_instr        <= w_nextInstr;
            r_idPc         <= w_nextIdPc;
            r_idValid      <= w_nextIdValid;
            r_redirPending <= w_nextPending;
            r_redirTarget  <= w_nextTarget;
            r_holdBuf      <= w_nextHoldBuf;
            r_holdPc       <= w_nextHoldPc;
        end
    end

    assign im_req      = (r_state == FETCH);
    assign im_addr     = r_fetchPc;
    assign Instruction = r_instr;
    assign id_pc       = r_idPc;
    assign id_pc4      = r_idPc + 32'd4;
    assign id_valid    = r_idValid;

endmodule
